// File: rtl/toothless_pkg.sv
// Shared types for the memory port arbiter: FSM state and transaction owner.
package toothless_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        WAIT_RVALID
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_LSU
    } arb_owner_e;

    localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_arb_prio.sv
// LSU-first winner select with a starvation guard that hands the port to IF
// once it has watched STARVE_LIMIT consecutive LSU grants.
module mem_arb_prio
    import toothless_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic lsu_req,
    input  logic if_gnt,
    input  logic lsu_gnt,
    output logic pick_if,
    output logic pick_lsu
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    logic [STARVE_CNT_W-1:0] starve_cnt;
    logic                    if_starved;

    assign if_starved = if_req && (starve_cnt >= LIMIT);
    assign pick_lsu   = lsu_req && !if_starved;
    assign pick_if    = if_req && !pick_lsu;

    // Counts only LSU grants that IF actually had to watch; any idle IF cycle forgives.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!if_req || if_gnt) begin
            starve_cnt <= '0;
        end else if (lsu_gnt && (starve_cnt < LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the LSU,
// one outstanding transaction at a time, responses routed to the owner only.
module mem_port_arbiter
    import toothless_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4,
    localparam int BE_WIDTH    = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,

    input  logic                  lsu_req_i,
    input  logic                  lsu_we_i,
    input  logic [BE_WIDTH-1:0]   lsu_be_i,
    input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
    input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
    output logic                  lsu_gnt_o,
    output logic                  lsu_rvalid_o,
    output logic [DATA_WIDTH-1:0] lsu_rdata_o,

    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [BE_WIDTH-1:0]   mem_be_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,

    output logic                  busy_o,
    output logic                  protocol_err_o
);

    arb_state_e state, state_d;
    arb_owner_e owner, owner_d;
    arb_owner_e sel;
    logic       pick_if, pick_lsu;
    logic       if_gnt, lsu_gnt, rsp_valid;

    mem_arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req_i),
        .lsu_req  (lsu_req_i),
        .if_gnt   (if_gnt),
        .lsu_gnt  (lsu_gnt),
        .pick_if  (pick_if),
        .pick_lsu (pick_lsu)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            owner          <= OWN_NONE;
            protocol_err_o <= 1'b0;
        end else begin
            state <= state_d;
            owner <= owner_d;
            if (mem_rvalid_i && (state != WAIT_RVALID)) begin
                protocol_err_o <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state;
        owner_d = owner;
        case (state)
            IDLE: begin
                if (pick_if || pick_lsu) begin
                    owner_d = pick_lsu ? OWN_LSU : OWN_IF;
                    state_d = mem_gnt_i ? WAIT_RVALID : WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                if (mem_gnt_i) state_d = WAIT_RVALID;
            end
            WAIT_RVALID: begin
                if (mem_rvalid_i) begin
                    state_d = IDLE;
                    owner_d = OWN_NONE;
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    // IDLE arbitrates live; WAIT_GNT replays the locked owner's current attributes.
    always_comb begin
        sel = OWN_NONE;
        case (state)
            IDLE:     sel = pick_lsu ? OWN_LSU : (pick_if ? OWN_IF : OWN_NONE);
            WAIT_GNT: sel = owner;
            default:  sel = OWN_NONE;
        endcase

        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (sel)
            OWN_LSU: begin
                mem_req_o   = 1'b1;
                mem_we_o    = lsu_we_i;
                mem_be_o    = lsu_be_i;
                mem_addr_o  = lsu_addr_i;
                mem_wdata_o = lsu_wdata_i;
            end
            OWN_IF: begin
                mem_req_o   = 1'b1;
                mem_be_o    = '1;
                mem_addr_o  = if_addr_i;
            end
            default: ;
        endcase

        if_gnt       = (sel == OWN_IF) && mem_gnt_i;
        lsu_gnt      = (sel == OWN_LSU) && mem_gnt_i;
        rsp_valid    = (state == WAIT_RVALID) && mem_rvalid_i;
        if_rvalid_o  = rsp_valid && (owner == OWN_IF);
        lsu_rvalid_o = rsp_valid && (owner == OWN_LSU);
        if_rdata_o   = if_rvalid_o ? mem_rdata_i : '0;
        lsu_rdata_o  = lsu_rvalid_o ? mem_rdata_i : '0;
        busy_o       = (state != IDLE);
    end

    assign if_gnt_o  = if_gnt;
    assign lsu_gnt_o = lsu_gnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level reference model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BW  = 4;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req_i;
    logic [AW-1:0] if_addr_i;
    logic          if_gnt_o, if_rvalid_o;
    logic [DW-1:0] if_rdata_o;
    logic          lsu_req_i, lsu_we_i;
    logic [BW-1:0] lsu_be_i;
    logic [AW-1:0] lsu_addr_i;
    logic [DW-1:0] lsu_wdata_i;
    logic          lsu_gnt_o, lsu_rvalid_o;
    logic [DW-1:0] lsu_rdata_o;
    logic          mem_req_o, mem_we_o;
    logic [BW-1:0] mem_be_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_gnt_i, mem_rvalid_i;
    logic [DW-1:0] mem_rdata_i;
    logic          busy_o, protocol_err_o;

    mem_port_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .STARVE_LIMIT (LIM)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .if_req_i       (if_req_i),
        .if_addr_i      (if_addr_i),
        .if_gnt_o       (if_gnt_o),
        .if_rvalid_o    (if_rvalid_o),
        .if_rdata_o     (if_rdata_o),
        .lsu_req_i      (lsu_req_i),
        .lsu_we_i       (lsu_we_i),
        .lsu_be_i       (lsu_be_i),
        .lsu_addr_i     (lsu_addr_i),
        .lsu_wdata_i    (lsu_wdata_i),
        .lsu_gnt_o      (lsu_gnt_o),
        .lsu_rvalid_o   (lsu_rvalid_o),
        .lsu_rdata_o    (lsu_rdata_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .busy_o         (busy_o),
        .protocol_err_o (protocol_err_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one transaction record (who, granted yet, store?) plus the
    // number of consecutive LSU grants IF has sat through.
    typedef struct {
        int          who;      // 0 none, 1 IF, 2 LSU presented on the memory port
        bit          req;
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          if_gnt;
        bit          lsu_gnt;
        bit          if_rv;
        bit          lsu_rv;
        bit          busy;
    } exp_t;

    bit m_ready   = 0;
    bit m_active  = 0;
    bit m_granted = 0;
    int m_who     = 0;
    bit m_store   = 0;
    int m_streak  = 0;
    bit m_err     = 0;

    function automatic exp_t model_eval();
        exp_t e;
        e = '{default: 0};
        if (!m_active) begin
            if (lsu_req_i && !(if_req_i && m_streak >= LIM)) e.who = 2;
            else if (if_req_i)                              e.who = 1;
        end else if (!m_granted) begin
            e.who = m_who;
        end
        e.req = (e.who != 0);
        if (e.who == 2) begin
            e.we = lsu_we_i; e.be = lsu_be_i; e.addr = lsu_addr_i; e.wdata = lsu_wdata_i;
        end else if (e.who == 1) begin
            e.be = 4'hF; e.addr = if_addr_i;
        end
        e.if_gnt  = (e.who == 1) && mem_gnt_i;
        e.lsu_gnt = (e.who == 2) && mem_gnt_i;
        e.if_rv   = m_granted && (m_who == 1) && mem_rvalid_i;
        e.lsu_rv  = m_granted && (m_who == 2) && mem_rvalid_i;
        e.busy    = m_active;
        return e;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        e = model_eval();
        if (rst) begin
            m_ready   <= 1;
            m_active  <= 0;
            m_granted <= 0;
            m_who     <= 0;
            m_streak  <= 0;
            m_err     <= 0;
        end else begin
            if (mem_rvalid_i && !m_granted) m_err <= 1;
            if (!m_active && e.who != 0) begin
                m_active  <= 1;
                m_who     <= e.who;
                m_granted <= mem_gnt_i;
                m_store   <= (e.who == 2) && lsu_we_i;
            end else if (m_active && !m_granted && mem_gnt_i) begin
                m_granted <= 1;
            end else if (m_granted && mem_rvalid_i) begin
                m_active  <= 0;
                m_granted <= 0;
                m_who     <= 0;
            end
            if (!if_req_i || e.if_gnt) m_streak <= 0;
            else if (e.lsu_gnt)        m_streak <= (m_streak + 1 > LIM) ? LIM : m_streak + 1;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (m_ready) begin
            e = model_eval();
            chk("model.mem_req", mem_req_o, e.req);
            chk("model.mem_we", mem_we_o, e.we);
            chk("model.mem_be", mem_be_o, e.be);
            chk("model.mem_addr", mem_addr_o, e.addr);
            if (e.who != 1) chk("model.mem_wdata", mem_wdata_o, e.wdata);
            chk("model.if_gnt", if_gnt_o, e.if_gnt);
            chk("model.lsu_gnt", lsu_gnt_o, e.lsu_gnt);
            chk("model.if_rvalid", if_rvalid_o, e.if_rv);
            chk("model.lsu_rvalid", lsu_rvalid_o, e.lsu_rv);
            chk("model.busy", busy_o, e.busy);
            chk("model.protocol_err", protocol_err_o, m_err);
            if (e.if_rv)              chk("model.if_rdata", if_rdata_o, mem_rdata_i);
            if (e.lsu_rv && !m_store) chk("model.lsu_rdata", lsu_rdata_o, mem_rdata_i);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  lsu_before, n_gnt, n_rv;
        bit  if_seen, gnt_prev;

        rst = 1; if_req_i = 0; if_addr_i = '0;
        lsu_req_i = 0; lsu_we_i = 0; lsu_be_i = '0; lsu_addr_i = '0; lsu_wdata_i = '0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
        step(); step();
        @(negedge clk);
        chk("reset.busy", busy_o, 0);
        chk("reset.mem_req", mem_req_o, 0);
        chk("reset.gnts", {if_gnt_o, lsu_gnt_o}, 0);
        chk("reset.err", protocol_err_o, 0);
        step(); rst = 0;

        // 1: IF only, immediate grant, response next cycle
        if_req_i = 1; if_addr_i = 32'h10; mem_gnt_i = 1;
        @(negedge clk);
        chk("t1.if_gnt", if_gnt_o, 1);
        chk("t1.mem_addr", mem_addr_o, 32'h10);
        chk("t1.mem_be", mem_be_o, 4'hF);
        step(); if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h00500093;
        @(negedge clk);
        chk("t1.if_rvalid", if_rvalid_o, 1);
        chk("t1.if_rdata", if_rdata_o, 32'h00500093);
        step(); mem_rvalid_i = 0;

        // 2: both request; LSU store wins, IF follows
        if_req_i = 1; if_addr_i = 32'h20;
        lsu_req_i = 1; lsu_we_i = 1; lsu_be_i = 4'hF; lsu_addr_i = 32'h100; lsu_wdata_i = 32'hDEADBEEF;
        mem_gnt_i = 1;
        @(negedge clk);
        chk("t2.lsu_gnt", lsu_gnt_o, 1);
        chk("t2.if_gnt", if_gnt_o, 0);
        chk("t2.mem_we", mem_we_o, 1);
        chk("t2.mem_wdata", mem_wdata_o, 32'hDEADBEEF);
        step(); lsu_req_i = 0; lsu_we_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h1;
        @(negedge clk);
        chk("t2.lsu_rvalid", lsu_rvalid_o, 1);
        chk("t2.if_rvalid_quiet", if_rvalid_o, 0);
        step(); mem_rvalid_i = 0; mem_gnt_i = 1;
        @(negedge clk);
        chk("t2.if_gnt_after", if_gnt_o, 1);
        chk("t2.if_addr", mem_addr_o, 32'h20);
        step(); if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h2;
        @(negedge clk);
        chk("t2.if_rvalid", if_rvalid_o, 1);
        step(); mem_rvalid_i = 0;

        // 3: starvation guard with LSU streaming loads
        if_req_i = 1; if_addr_i = 32'h40;
        lsu_req_i = 1; lsu_we_i = 0; lsu_be_i = 4'hF; lsu_addr_i = 32'h1000; mem_gnt_i = 1;
        lsu_before = 0; if_seen = 0;
        for (int c = 0; c < 30 && !if_seen; c++) begin
            @(negedge clk);
            if (if_gnt_o) if_seen = 1;
            else if (lsu_gnt_o) lsu_before++;
            gnt_prev = if_gnt_o || lsu_gnt_o;
            step();
            mem_rvalid_i = gnt_prev; mem_rdata_i = 32'h1000 + c;
            if (gnt_prev) lsu_addr_i = lsu_addr_i + 4;
            if (if_seen) if_req_i = 0;
        end
        chk("t3.if_granted", if_seen, 1);
        chk("t3.lsu_grants_before_if", lsu_before, 4);
        @(negedge clk);
        chk("t3.if_rvalid", if_rvalid_o, 1);
        step(); mem_rvalid_i = 0;
        @(negedge clk);
        chk("t3.lsu_next", lsu_gnt_o, 1);
        step(); lsu_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1;
        step(); mem_rvalid_i = 0;

        // 4: grant stall with IF locked while LSU arrives
        if_req_i = 1; if_addr_i = 32'h80;
        @(negedge clk);
        chk("t4.mem_req", mem_req_o, 1);
        step(); lsu_req_i = 1; lsu_addr_i = 32'h200;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("t4.addr_stable", mem_addr_o, 32'h80);
            chk("t4.no_lsu_gnt", lsu_gnt_o, 0);
            step();
        end
        mem_gnt_i = 1;
        @(negedge clk);
        chk("t4.if_gnt", if_gnt_o, 1);
        chk("t4.lsu_held", lsu_gnt_o, 0);
        step(); if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h44;
        @(negedge clk);
        chk("t4.if_rvalid", if_rvalid_o, 1);
        chk("t4.lsu_still_held", lsu_gnt_o, 0);
        step(); mem_rvalid_i = 0; mem_gnt_i = 1;
        @(negedge clk);
        chk("t4.lsu_gnt", lsu_gnt_o, 1);
        chk("t4.lsu_addr", mem_addr_o, 32'h200);
        step(); lsu_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1;
        step(); mem_rvalid_i = 0;

        // 6: back-to-back loads, one every 2 cycles
        lsu_req_i = 1; lsu_we_i = 0; lsu_addr_i = 32'h3000; mem_gnt_i = 1;
        n_gnt = 0; n_rv = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_gnt += int'(lsu_gnt_o);
            n_rv  += int'(lsu_rvalid_o);
            gnt_prev = lsu_gnt_o;
            step();
            mem_rvalid_i = gnt_prev; mem_rdata_i = 32'hA000 + c;
            if (gnt_prev) lsu_addr_i = lsu_addr_i + 4;
        end
        chk("t6.grants", n_gnt, 5);
        chk("t6.rvalids", n_rv, 5);
        lsu_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;

        // 5: reset mid-transaction, then a stray response
        lsu_req_i = 1; lsu_addr_i = 32'h300; mem_gnt_i = 1;
        @(negedge clk);
        chk("t5.lsu_gnt", lsu_gnt_o, 1);
        step(); lsu_req_i = 0; mem_gnt_i = 0; rst = 1;
        step(); rst = 0;
        @(negedge clk);
        chk("t5.busy", busy_o, 0);
        chk("t5.valids", {if_rvalid_o, lsu_rvalid_o, if_gnt_o, lsu_gnt_o}, 0);
        step(); mem_rvalid_i = 1; mem_rdata_i = 32'h55;
        @(negedge clk);
        chk("t5.stray_dropped", lsu_rvalid_o, 0);
        step(); mem_rvalid_i = 0;
        @(negedge clk);
        chk("t5.err_set", protocol_err_o, 1);
        step(); rst = 1;
        step(); rst = 0;
        @(negedge clk);
        chk("t5.err_cleared", protocol_err_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
